// File: rtl/alu_4bit_arbiter.sv
// Round-robin arbiter that shares one 4-bit ALU among NUM_REQ requesters,
// issuing one operation at a time and returning result/error/ID on a response bus.
module alu_4bit_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 15
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [4*NUM_REQ-1:0]   req_a,
    input  logic [4*NUM_REQ-1:0]   req_b,
    input  logic [2*NUM_REQ-1:0]   req_op,
    output logic [NUM_REQ-1:0]     gnt,
    output logic                   busy,
    output logic                   rsp_valid,
    output logic [1:0]             rsp_id,
    output logic [7:0]             rsp_result,
    output logic                   rsp_error,
    output logic                   rsp_timeout,
    output logic [3:0]             alu_a,
    output logic [3:0]             alu_b,
    output logic [1:0]             alu_opcode,
    output logic                   alu_start,
    input  logic [7:0]             alu_result,
    input  logic                   alu_done,
    input  logic                   alu_error
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t               state_reg, state_next;
    logic [1:0]           ptr_reg;
    logic [3:0]           cnt_reg;
    logic [NUM_REQ-1:0]   gnt_reg;
    logic [1:0]           rsp_id_reg;
    logic [7:0]           rsp_result_reg;
    logic                 rsp_error_reg;
    logic                 rsp_timeout_reg;
    logic [3:0]           alu_a_reg;
    logic [3:0]           alu_b_reg;
    logic [1:0]           alu_opcode_reg;

    logic [3:0]           a_arr  [4];
    logic [3:0]           b_arr  [4];
    logic [1:0]           op_arr [4];
    logic [7:0]           req_pad;

    logic                 win_valid;
    logic [1:0]           win_idx;
    logic [2:0]           cand;
    logic [1:0]           ptr_next;
    logic [NUM_REQ-1:0]   win_onehot;
    logic                 wait_expired;

    // Unpack per-requester fields; slots beyond NUM_REQ read as zero and never request.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_unpack
            if (gi < NUM_REQ) begin : g_live
                assign a_arr[gi]  = req_a[4*gi +: 4];
                assign b_arr[gi]  = req_b[4*gi +: 4];
                assign op_arr[gi] = req_op[2*gi +: 2];
            end else begin : g_tie
                assign a_arr[gi]  = 4'd0;
                assign b_arr[gi]  = 4'd0;
                assign op_arr[gi] = 2'd0;
            end
        end
        for (gi = 0; gi < 8; gi++) begin : g_req_pad
            if (gi < NUM_REQ) begin : g_live
                assign req_pad[gi] = req[gi];
            end else begin : g_tie
                assign req_pad[gi] = 1'b0;
            end
        end
    endgenerate

    // Scan from the farthest offset back to the pointer so the nearest set bit wins.
    always_comb begin
        win_valid = 1'b0;
        win_idx   = 2'd0;
        cand      = 3'd0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            cand = {1'b0, ptr_reg} + 3'(i);
            if (cand >= 3'(NUM_REQ)) begin
                cand = cand - 3'(NUM_REQ);
            end
            if (req_pad[cand]) begin
                win_valid = 1'b1;
                win_idx   = cand[1:0];
            end
        end
    end

    always_comb begin
        ptr_next   = (win_idx == 2'(NUM_REQ - 1)) ? 2'd0 : win_idx + 2'd1;
        win_onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << win_idx;
    end

    assign wait_expired = (cnt_reg == 4'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:  if (win_valid) state_next = S_ISSUE;
            S_ISSUE: state_next = S_WAIT;
            S_WAIT:  if (alu_done || wait_expired) state_next = S_RESP;
            S_RESP:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy      = (state_reg != S_IDLE);
        alu_start = (state_reg == S_ISSUE);
        rsp_valid = (state_reg == S_RESP);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr_reg         <= 2'd0;
            cnt_reg         <= 4'd0;
            gnt_reg         <= '0;
            rsp_id_reg      <= 2'd0;
            rsp_result_reg  <= 8'd0;
            rsp_error_reg   <= 1'b0;
            rsp_timeout_reg <= 1'b0;
            alu_a_reg       <= 4'd0;
            alu_b_reg       <= 4'd0;
            alu_opcode_reg  <= 2'd0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (win_valid) begin
                        alu_a_reg      <= a_arr[win_idx];
                        alu_b_reg      <= b_arr[win_idx];
                        alu_opcode_reg <= op_arr[win_idx];
                        gnt_reg        <= win_onehot;
                        rsp_id_reg     <= win_idx;
                        ptr_reg        <= ptr_next;
                    end
                end
                S_ISSUE: begin
                    cnt_reg <= 4'd0;
                end
                S_WAIT: begin
                    // A done arriving on the expiry edge still counts as a real completion.
                    if (alu_done) begin
                        rsp_result_reg  <= alu_result;
                        rsp_error_reg   <= alu_error;
                        rsp_timeout_reg <= 1'b0;
                    end else if (wait_expired) begin
                        rsp_result_reg  <= 8'd0;
                        rsp_error_reg   <= 1'b1;
                        rsp_timeout_reg <= 1'b1;
                    end else begin
                        cnt_reg <= cnt_reg + 4'd1;
                    end
                end
                S_RESP: begin
                    gnt_reg <= '0;
                end
                default: ;
            endcase
        end
    end

    assign gnt         = gnt_reg;
    assign rsp_id      = rsp_id_reg;
    assign rsp_result  = rsp_result_reg;
    assign rsp_error   = rsp_error_reg;
    assign rsp_timeout = rsp_timeout_reg;
    assign alu_a       = alu_a_reg;
    assign alu_b       = alu_b_reg;
    assign alu_opcode  = alu_opcode_reg;

endmodule
